// File: rtl/max_reg_arbiter.sv
// max_reg_arbiter: round-robin arbiter sharing the MAX3421E SPI byte engine between two
// register-access requesters, each grant running one command+data byte transaction.
module max_reg_arbiter #(
   parameter int SS_GAP = 2
) (
   input  logic        clk_in,
   input  logic        n_rst_in,
   input  logic [1:0]  req_in,
   input  logic [1:0]  wr_in,
   input  logic [9:0]  addr_in,
   input  logic [15:0] wdata_in,
   output logic [1:0]  ack_out,
   output logic [7:0]  rdata_out,
   output logic [7:0]  status_out,
   output logic        busy_out,
   output logic        byte_start_out,
   output logic [7:0]  byte_tx_out,
   input  logic        byte_done_in,
   input  logic [7:0]  byte_rx_in,
   output logic        n_ss_out
);
   localparam int CW = (SS_GAP < 2) ? 1 : $clog2(SS_GAP);
   typedef enum logic [2:0] {IDLE, CMD, CMD_WAIT, DATA, DATA_WAIT, GAP} state_t;
   state_t          r_state;
   logic            r_g, r_rr, r_wr, r_busy, r_start, r_n_ss;
   logic [4:0]      r_addr;
   logic [7:0]      r_wdata, r_tx, r_rdata, r_status;
   logic [1:0]      r_ack;
   logic [CW-1:0]   r_cnt;
   logic            w_g;
   // r_rr holds the last granted requester; on contention the other one wins
   assign w_g = (req_in == 2'b11) ? ~r_rr : req_in[1];
   always_ff @(posedge clk_in) begin
      if (!n_rst_in) begin
         r_state  <= IDLE;
         r_g      <= 1'b0;
         r_rr     <= 1'b1;
         r_wr     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_busy   <= 1'b0;
         r_start  <= 1'b0;
         r_n_ss   <= 1'b1;
         r_tx     <= '0;
         r_rdata  <= '0;
         r_status <= '0;
         r_ack    <= '0;
         r_cnt    <= '0;
      end else begin
         r_start <= 1'b0;
         r_ack   <= '0;
         case (r_state)
            IDLE: if (|req_in) begin
               r_g     <= w_g;
               r_wr    <= wr_in[w_g];
               r_addr  <= w_g ? addr_in[9:5] : addr_in[4:0];
               r_wdata <= w_g ? wdata_in[15:8] : wdata_in[7:0];
               r_n_ss  <= 1'b0;
               r_busy  <= 1'b1;
               r_state <= CMD;
            end
            CMD: begin
               r_start <= 1'b1;
               r_tx    <= {r_addr, 1'b0, r_wr, 1'b0};
               r_state <= CMD_WAIT;
            end
            CMD_WAIT: if (byte_done_in) begin
               r_status <= byte_rx_in;
               r_state  <= DATA;
            end
            DATA: begin
               r_start <= 1'b1;
               r_tx    <= r_wr ? r_wdata : 8'h00;
               r_state <= DATA_WAIT;
            end
            DATA_WAIT: if (byte_done_in) begin
               r_ack   <= r_g ? 2'b10 : 2'b01;
               r_n_ss  <= 1'b1;
               r_rdata <= r_wr ? r_rdata : byte_rx_in;
               r_rr    <= r_g;
               r_cnt   <= '0;
               r_state <= GAP;
            end
            GAP: if (r_cnt == CW'(SS_GAP - 1)) begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign ack_out        = r_ack;
   assign rdata_out      = r_rdata;
   assign status_out     = r_status;
   assign busy_out       = r_busy;
   assign byte_start_out = r_start;
   assign byte_tx_out    = r_tx;
   assign n_ss_out       = r_n_ss;
endmodule

// File: tb/tb_max_reg_arbiter.sv
// tb_max_reg_arbiter: directed-vector bench for max_reg_arbiter; the bench plays both
// requesters and the SPI byte engine.
module tb_max_reg_arbiter;
   logic        clk_in = 1'b0, n_rst_in = 1'b0, byte_start_out, busy_out, n_ss_out, byte_done_in = 1'b0;
   logic [1:0]  req_in = '0, wr_in = '0, ack_out;
   logic [9:0]  addr_in = '0;
   logic [15:0] wdata_in = '0;
   logic [7:0]  rdata_out, status_out, byte_tx_out, byte_rx_in = '0, tx;
   int checks = 0, errors = 0;

   max_reg_arbiter #(.SS_GAP(2)) dut (
      .clk_in(clk_in), .n_rst_in(n_rst_in), .req_in(req_in), .wr_in(wr_in),
      .addr_in(addr_in), .wdata_in(wdata_in), .ack_out(ack_out), .rdata_out(rdata_out),
      .status_out(status_out), .busy_out(busy_out), .byte_start_out(byte_start_out),
      .byte_tx_out(byte_tx_out), .byte_done_in(byte_done_in), .byte_rx_in(byte_rx_in),
      .n_ss_out(n_ss_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   // Engine model: wait for a start pulse, return the shifted byte, answer with rx after two cycles
   task automatic serve_byte(input logic [7:0] rx, output logic [7:0] seen_tx);
      bit seen = 0;
      seen_tx = 8'hxx;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick;
         if (byte_start_out) begin
            seen = 1;
            seen_tx = byte_tx_out;
         end
      end
      if (seen) begin
         tick;
         tick;
         byte_done_in = 1'b1;
         byte_rx_in = rx;
         tick;
         byte_done_in = 1'b0;
         byte_rx_in = '0;
      end
   endtask

   task automatic test_reset;
      n_rst_in = 1'b0;
      tick;
      tick;
      checks++; if (n_ss_out !== 1'b1) begin errors++; $display("FAIL reset_n_ss got %b want 1", n_ss_out); end
      checks++; if (byte_start_out !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", byte_start_out); end
      checks++; if (ack_out !== 2'b00) begin errors++; $display("FAIL reset_ack got %b want 00", ack_out); end
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_out); end
      checks++; if ({rdata_out, status_out, byte_tx_out} !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 000000", {rdata_out, status_out, byte_tx_out}); end
      n_rst_in = 1'b1;
      tick;
   endtask

   task automatic test_single_write;
      req_in = 2'b01; wr_in = 2'b01; addr_in = {5'd0, 5'd17}; wdata_in = 16'h0001;
      serve_byte(8'h11, tx);
      checks++; if (tx !== 8'h8A) begin errors++; $display("FAIL wr_cmd got %h want 8a", tx); end
      checks++; if (n_ss_out !== 1'b0 || busy_out !== 1'b1) begin errors++; $display("FAIL wr_ss_mid got n_ss=%b busy=%b want 0 1", n_ss_out, busy_out); end
      checks++; if (status_out !== 8'h11) begin errors++; $display("FAIL wr_status got %h want 11", status_out); end
      serve_byte(8'h22, tx);
      checks++; if (tx !== 8'h01) begin errors++; $display("FAIL wr_data got %h want 01", tx); end
      checks++; if (ack_out !== 2'b01) begin errors++; $display("FAIL wr_ack got %b want 01", ack_out); end
      checks++; if (rdata_out !== 8'h00 || n_ss_out !== 1'b1) begin errors++; $display("FAIL wr_ack_cycle got rdata=%h n_ss=%b want 00 1", rdata_out, n_ss_out); end
      req_in = 2'b00;
      tick;
      checks++; if (ack_out !== 2'b00 || n_ss_out !== 1'b1 || busy_out !== 1'b1) begin errors++; $display("FAIL wr_gap1 got ack=%b n_ss=%b busy=%b want 00 1 1", ack_out, n_ss_out, busy_out); end
      tick;
      checks++; if (busy_out !== 1'b0 || n_ss_out !== 1'b1) begin errors++; $display("FAIL wr_idle got busy=%b n_ss=%b want 0 1", busy_out, n_ss_out); end
   endtask

   task automatic test_single_read;
      req_in = 2'b10; wr_in = 2'b00; addr_in = {5'd19, 5'd0}; wdata_in = 16'hFFFF;
      serve_byte(8'h5C, tx);
      checks++; if (tx !== 8'h98) begin errors++; $display("FAIL rd_cmd got %h want 98", tx); end
      checks++; if (status_out !== 8'h5C) begin errors++; $display("FAIL rd_status got %h want 5c", status_out); end
      serve_byte(8'hA7, tx);
      checks++; if (tx !== 8'h00) begin errors++; $display("FAIL rd_data_tx got %h want 00", tx); end
      checks++; if (ack_out !== 2'b10 || rdata_out !== 8'hA7) begin errors++; $display("FAIL rd_ack got ack=%b rdata=%h want 10 a7", ack_out, rdata_out); end
      req_in = 2'b00;
      tick;
      tick;
   endtask

   task automatic test_round_robin;
      logic g;
      req_in = 2'b11; wr_in = 2'b11; addr_in = {5'd2, 5'd1}; wdata_in = 16'hB2A1;
      for (int t = 0; t < 3; t++) begin
         g = (t == 1);
         serve_byte(8'h40, tx);
         checks++; if (tx !== (g ? 8'h12 : 8'h0A)) begin errors++; $display("FAIL rr_cmd%0d got %h want %h", t, tx, g ? 8'h12 : 8'h0A); end
         serve_byte(8'h00, tx);
         checks++; if (tx !== (g ? 8'hB2 : 8'hA1)) begin errors++; $display("FAIL rr_data%0d got %h want %h", t, tx, g ? 8'hB2 : 8'hA1); end
         checks++; if (ack_out !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ack%0d got %b want %b", t, ack_out, g ? 2'b10 : 2'b01); end
         if (t == 2) req_in = 2'b00;
         tick;
         checks++; if (ack_out !== 2'b00 || byte_start_out !== 1'b0) begin errors++; $display("FAIL rr_gap_a%0d got ack=%b start=%b want 00 0", t, ack_out, byte_start_out); end
         tick;
         checks++; if (byte_start_out !== 1'b0 || n_ss_out !== 1'b1) begin errors++; $display("FAIL rr_gap_b%0d got start=%b n_ss=%b want 0 1", t, byte_start_out, n_ss_out); end
      end
   endtask

   task automatic test_latch;
      req_in = 2'b01; wr_in = 2'b01; addr_in = {5'd0, 5'd5}; wdata_in = 16'h0033;
      serve_byte(8'h00, tx);
      checks++; if (tx !== 8'h2A) begin errors++; $display("FAIL latch_cmd got %h want 2a", tx); end
      wdata_in = 16'h0044; addr_in = '0; wr_in = 2'b00;
      serve_byte(8'h00, tx);
      checks++; if (tx !== 8'h33) begin errors++; $display("FAIL latch_data got %h want 33", tx); end
      checks++; if (ack_out !== 2'b01) begin errors++; $display("FAIL latch_ack got %b want 01", ack_out); end
      req_in = 2'b00;
      tick;
      tick;
   endtask

   task automatic test_reset_mid;
      bit seen = 0;
      req_in = 2'b10; wr_in = 2'b00; addr_in = {5'd3, 5'd0};
      serve_byte(8'h77, tx);
      checks++; if (tx !== 8'h18) begin errors++; $display("FAIL rst_cmd got %h want 18", tx); end
      for (int i = 0; i < 20 && !seen; i++) begin
         tick;
         seen = byte_start_out;
      end
      checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rst_data_start got %b want 1", seen); end
      n_rst_in = 1'b0; req_in = 2'b00;
      tick;
      checks++; if (n_ss_out !== 1'b1 || ack_out !== 2'b00 || busy_out !== 1'b0) begin errors++; $display("FAIL rst_abort got n_ss=%b ack=%b busy=%b want 1 00 0", n_ss_out, ack_out, busy_out); end
      n_rst_in = 1'b1;
      byte_done_in = 1'b1; byte_rx_in = 8'hEE;
      tick;
      byte_done_in = 1'b0; byte_rx_in = '0;
      tick;
      checks++; if (ack_out !== 2'b00 || busy_out !== 1'b0 || status_out !== 8'h00 || rdata_out !== 8'h00) begin errors++; $display("FAIL rst_stray got ack=%b busy=%b status=%h rdata=%h want 00 0 00 00", ack_out, busy_out, status_out, rdata_out); end
      req_in = 2'b01; wr_in = 2'b01; addr_in = {5'd0, 5'd4}; wdata_in = 16'h005A;
      serve_byte(8'h66, tx);
      checks++; if (tx !== 8'h22) begin errors++; $display("FAIL rst_fresh_cmd got %h want 22", tx); end
      serve_byte(8'h00, tx);
      checks++; if (tx !== 8'h5A || ack_out !== 2'b01) begin errors++; $display("FAIL rst_fresh got tx=%h ack=%b want 5a 01", tx, ack_out); end
      req_in = 2'b00;
      tick;
      tick;
   endtask

   task automatic test_spurious;
      byte_done_in = 1'b1; byte_rx_in = 8'hFF;
      tick;
      byte_done_in = 1'b0; byte_rx_in = '0;
      tick;
      checks++; if (busy_out !== 1'b0 || n_ss_out !== 1'b1 || byte_start_out !== 1'b0 || status_out !== 8'h66 || rdata_out !== 8'h00) begin errors++; $display("FAIL spur_idle got busy=%b n_ss=%b start=%b status=%h rdata=%h want 0 1 0 66 00", busy_out, n_ss_out, byte_start_out, status_out, rdata_out); end
      req_in = 2'b10; wr_in = 2'b00; addr_in = {5'd7, 5'd0};
      serve_byte(8'h3C, tx);
      serve_byte(8'h99, tx);
      checks++; if (ack_out !== 2'b10 || rdata_out !== 8'h99) begin errors++; $display("FAIL spur_rd got ack=%b rdata=%h want 10 99", ack_out, rdata_out); end
      req_in = 2'b00;
      byte_done_in = 1'b1; byte_rx_in = 8'hFF;
      tick;
      byte_done_in = 1'b0; byte_rx_in = '0;
      checks++; if (status_out !== 8'h3C || rdata_out !== 8'h99 || ack_out !== 2'b00 || n_ss_out !== 1'b1 || busy_out !== 1'b1) begin errors++; $display("FAIL spur_gap got status=%h rdata=%h ack=%b n_ss=%b busy=%b want 3c 99 00 1 1", status_out, rdata_out, ack_out, n_ss_out, busy_out); end
      tick;
      checks++; if (busy_out !== 1'b0 || byte_start_out !== 1'b0) begin errors++; $display("FAIL spur_end got busy=%b start=%b want 0 0", busy_out, byte_start_out); end
   endtask

   initial begin
      test_reset;
      test_single_write;
      test_single_read;
      test_round_robin;
      test_latch;
      test_reset_mid;
      test_spurious;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
